// File: rtl/montgomery_precompute_if.sv
// montgomery_precompute_if: request/result bundle between the precompute stage and its host.
`ifndef BITS
`define BITS 8
`endif
interface montgomery_precompute_if #(parameter int BITS = `BITS);
  logic start;
  logic [BITS-1:0] base;
  logic [BITS-1:0] N;
  logic busy;
  logic finish;
  logic error;
  logic [BITS-1:0] N_prime;
  logic [BITS-1:0] one_mont;
  logic [BITS-1:0] base_mont;
  modport master (output start, base, N, input busy, finish, error, N_prime, one_mont, base_mont);
  modport slave (input start, base, N, output busy, finish, error, N_prime, one_mont, base_mont);
endinterface

// File: rtl/montgomery_precompute.sv
// montgomery_precompute: N_prime = -N^-1 mod R, R mod N and base*R mod N using shift/add/compare only.
// Input validation and the error flag exist only when MONT_PRECOMP_CHECK_EN is defined.
module montgomery_precompute #(parameter int BITS = `BITS) (
  input logic clk,
  input logic rst,
  montgomery_precompute_if.slave s
);
  localparam int CW = $clog2(BITS);
  localparam logic [CW-1:0] LAST = CW'(BITS - 1);
  typedef enum logic [1:0] {IDLE, CHECK, RUN, DONE} state_t;
  state_t st, nxt;
  logic [BITS-1:0] bq, nq, x, p, x_n, p_n, np, om, bm;
  logic [BITS:0] r1, rb, r1_n, rb_n;
  logic [CW-1:0] cnt;
  logic bad;
  function automatic logic [BITS:0] dbl(input logic [BITS:0] r, input logic [BITS-1:0] n);
    logic [BITS:0] d;
    d = r << 1;
    return (d >= {1'b0, n}) ? d - {1'b0, n} : d;
  endfunction
`ifdef MONT_PRECOMP_CHECK_EN
  logic err;
  assign bad = !nq[0] || nq < BITS'(3) || bq >= nq;
  assign s.error = err;
  always_ff @(posedge clk or negedge rst)
    if (!rst) err <= 1'b0;
    else if (st == IDLE && s.start) err <= 1'b0;
    else if (st == CHECK && bad) err <= 1'b1;
`else
  assign bad = 1'b0;
  assign s.error = 1'b0;
`endif
  assign s.busy = st != IDLE;
  assign s.finish = st == DONE;
  assign s.N_prime = np;
  assign s.one_mont = om;
  assign s.base_mont = bm;
  assign r1_n = dbl(r1, nq);
  assign rb_n = dbl(rb, nq);
  // Hensel lifting: p = N*x mod R is 1 in its low cnt bits, so bit cnt decides x[cnt].
  always_comb begin
    x_n = x;
    p_n = p;
    if (cnt != '0 && p[cnt]) begin
      x_n[cnt] = 1'b1;
      p_n = p + (nq << cnt);
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) st <= IDLE;
    else st <= nxt;
  always_comb begin
    nxt = st;
    case (st)
      IDLE: nxt = s.start ? CHECK : IDLE;
      CHECK: nxt = bad ? DONE : RUN;
      RUN: nxt = (cnt == LAST) ? DONE : RUN;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bq <= '0;
      nq <= '0;
      x <= '0;
      p <= '0;
      r1 <= '0;
      rb <= '0;
      cnt <= '0;
      np <= '0;
      om <= '0;
      bm <= '0;
    end else begin
      case (st)
        IDLE: if (s.start) begin
          bq <= s.base;
          nq <= s.N;
        end
        CHECK: if (bad) begin
          np <= '0;
          om <= '0;
          bm <= '0;
        end else begin
          x <= BITS'(1);
          p <= nq;
          r1 <= (BITS + 1)'(1);
          rb <= {1'b0, bq};
          cnt <= '0;
        end
        RUN: begin
          x <= x_n;
          p <= p_n;
          r1 <= r1_n;
          rb <= rb_n;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            np <= ~x_n + 1'b1;
            om <= r1_n[BITS-1:0];
            bm <= rb_n[BITS-1:0];
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_montgomery_precompute.sv
// tb_montgomery_precompute: directed vectors for BITS=8, expectations adapt to MONT_PRECOMP_CHECK_EN.
module tb_montgomery_precompute;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int lat;
  int nfin;
  always #5 clk = ~clk;
  montgomery_precompute_if #(.BITS(8)) m();
  montgomery_precompute #(.BITS(8)) dut (.clk(clk), .rst(rst), .s(m.slave));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic res(input string tag, input logic [31:0] np, input logic [31:0] om, input logic [31:0] bm);
    chk({tag, "_N_prime"}, 32'(m.N_prime), np);
    chk({tag, "_one_mont"}, 32'(m.one_mont), om);
    chk({tag, "_base_mont"}, 32'(m.base_mont), bm);
  endtask
  task automatic go(input logic [7:0] b, input logic [7:0] n);
    @(negedge clk);
    for (int i = 0; i < 40 && m.busy; i++) @(negedge clk);
    m.base = b;
    m.N = n;
    m.start = 1'b1;
    @(posedge clk);
    #1;
    chk("busy_after_accept", 32'(m.busy), 1);
  endtask
  task automatic wait_fin(output int l);
    l = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (m.finish) begin
        l = c;
        break;
      end
    end
  endtask
  initial begin
    m.start = 1'b0;
    m.base = '0;
    m.N = '0;
    #2 rst = 1'b0;
    #10;
    chk("rst_busy", 32'(m.busy), 0);
    chk("rst_finish", 32'(m.finish), 0);
    chk("rst_error", 32'(m.error), 0);
    res("rst", 0, 0, 0);
    @(negedge clk) rst = 1'b1;
    go(8'd5, 8'd13);
    m.start = 1'b0;
    wait_fin(lat);
    chk("b5n13_latency", lat, 9);
    chk("b5n13_error", 32'(m.error), 0);
    res("b5n13", 59, 9, 6);
    @(posedge clk);
    #1;
    chk("finish_width", 32'(m.finish), 0);
    chk("busy_after_done", 32'(m.busy), 0);
    go(8'd254, 8'd255);
    wait_fin(lat);
    chk("b254n255_latency", lat, 9);
    res("b254n255", 1, 1, 254);
    m.base = 8'd0;
    m.N = 8'd3;
    wait_fin(lat);
    m.start = 1'b0;
    chk("b2b_latency", lat, 11);
    res("b0n3", 85, 1, 0);
    go(8'd1, 8'd12);
    m.start = 1'b0;
    wait_fin(lat);
`ifdef MONT_PRECOMP_CHECK_EN
    chk("even_n_latency", lat, 1);
    chk("even_n_error", 32'(m.error), 1);
    res("even_n", 0, 0, 0);
`else
    chk("even_n_latency", lat, 9);
    chk("even_n_error", 32'(m.error), 0);
`endif
    go(8'd5, 8'd13);
    m.start = 1'b0;
    chk("error_cleared", 32'(m.error), 0);
    wait_fin(lat);
    chk("recover_latency", lat, 9);
    res("recover", 59, 9, 6);
    go(8'd13, 8'd13);
    m.start = 1'b0;
    wait_fin(lat);
`ifdef MONT_PRECOMP_CHECK_EN
    chk("base_eq_n_latency", lat, 1);
    chk("base_eq_n_error", 32'(m.error), 1);
`else
    chk("base_eq_n_latency", lat, 9);
    chk("base_eq_n_error", 32'(m.error), 0);
`endif
    go(8'd5, 8'd13);
    m.start = 1'b0;
    nfin = 0;
    lat = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      m.start = (c == 3 || c == 5);
      @(posedge clk);
      #1;
      if (m.finish) begin
        nfin++;
        if (lat == 0) lat = c;
      end
    end
    m.start = 1'b0;
    chk("busy_start_finishes", nfin, 1);
    chk("busy_start_latency", lat, 9);
    res("busy_start", 59, 9, 6);
    go(8'd5, 8'd13);
    m.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", 32'(m.busy), 0);
    chk("abort_finish", 32'(m.finish), 0);
    chk("abort_error", 32'(m.error), 0);
    res("abort", 0, 0, 0);
    nfin = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (m.finish) nfin++;
    end
    @(negedge clk) rst = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (m.finish) nfin++;
    end
    chk("abort_no_finish", nfin, 0);
    go(8'd254, 8'd255);
    m.start = 1'b0;
    wait_fin(lat);
    chk("after_abort_latency", lat, 9);
    res("after_abort", 1, 1, 254);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/montgomery_precompute.md
# montgomery_precompute

Hardware pre-computation stage placed directly upstream of `montgomery_exp_square`. For a base and an odd modulus N, it produces the three Montgomery operands that the exponentiator consumes, with R = 2^BITS:
- N_prime = −N⁻¹ mod R
- one_mont = R mod N
- base_mont = base·R mod N

This removes the software-side extended-Euclid/division step. It uses only shift, add, subtract and compare; no multiplier or divider.

## Interface
Parameters:
- BITS, default `BITS (defines.vh), operand width; R = 2^BITS.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- base  in  BITS  plain-domain base; must be < N.
- N  in  BITS  modulus; must be odd and ≥ 3.
- busy  out  1  high in every state except IDLE.
- finish  out  1  one-cycle pulse; outputs are valid from this cycle onward.
- error  out  1  invalid inputs detected; held until the next accepted start.
- N_prime  out  BITS  −N⁻¹ mod 2^BITS.
- one_mont  out  BITS  2^BITS mod N.
- base_mont  out  BITS  base·2^BITS mod N.

## Operation
- Reset (async, rst=0): state=IDLE. busy, finish, error, N_prime, one_mont and base_mont are all 0.
- Inputs base and N are captured into internal registers at the accepting edge. They may change afterwards.
- FSM states: IDLE → CHECK → RUN → DONE → IDLE.
  - IDLE: on start=1, capture inputs, clear error, go to CHECK.
  - CHECK: validate inputs. If N[0]=0, N<3 or base≥N, go to DONE with error=1 and all result outputs forced to 0. Otherwise go to RUN with cnt=0 and initialise:
    - x=1, p=N (p tracks N·x mod R)
    - r1=1, rb=base (both BITS+1 wide)
  - RUN: one iteration per cycle, cnt = 0..BITS−1.
    - Modular doubling on r1 and rb every iteration: r ← 2r; if r ≥ N then r ← r − N. Compare and subtract are done at BITS+1 width.
    - Inverse lifting for cnt ≥ 1: if p[cnt]=1, then x[cnt] ← 1 and p ← (p + (N<<cnt)) mod 2^BITS. Iteration 0 leaves x and p unchanged.
    - After iteration BITS−1, load the outputs and go to DONE:
      - N_prime ← (~x + 1) mod 2^BITS
      - one_mont ← r1[BITS-1:0]
      - base_mont ← rb[BITS-1:0]
  - DONE: finish=1 for exactly this cycle, then return to IDLE.
- Outputs hold their values until the next accepted start. They are then held unchanged until loaded in the next DONE (or zeroed on an error).
- start while busy=1 is ignored and has no side effects. start held high continuously re-triggers in the cycle after DONE.
- Invariant on exit: N·x ≡ 1 (mod 2^BITS), hence N·N_prime ≡ −1.

## Timing
Cycle numbering: edge e0 is the edge that samples start=1 in IDLE.
- Valid inputs: RUN occupies edges e2…e(BITS+1). finish is high between e(BITS+1) and e(BITS+2). Latency is BITS+1 cycles and is data-independent.
- Invalid inputs: finish and error are high between e1 and e2. Latency is 1 cycle.
- busy rises after e0 and falls after the edge at which DONE exits.
- The earliest next accept is the edge at which DONE exits, if start=1 in DONE is treated as IDLE-sampled on the following edge. Precisely: the next accept is at e(BITS+3) (valid case) or e3 (invalid case).
- Reset asserted mid-RUN aborts immediately: no finish pulse, and all outputs are cleared to 0.

## Configuration
- MONT_PRECOMP_CHECK_EN defined: the CHECK-state validation and the error path are as described above.
- MONT_PRECOMP_CHECK_EN undefined:
  - No validation; error is tied to 0.
  - CHECK always proceeds to RUN, so latency stays BITS+1.
  - Results for invalid inputs are unspecified, but the FSM and handshake are unaffected.

## Test plan
All scenarios use BITS=8 with MONT_PRECOMP_CHECK_EN defined unless stated.
- base=5, N=13 → N_prime=59, one_mont=9, base_mont=6, error=0. finish pulses exactly 9 cycles after the start edge and stays high for 1 cycle.
- base=254, N=255 → N_prime=1, one_mont=1, base_mont=254. Then base=0, N=3 → N_prime=85, one_mont=1, base_mont=0. The two runs are issued back-to-back with start held high.
- N=12, base=1 → error=1, all results 0, finish 1 cycle after the start edge. A following valid request (base=5, N=13) clears error and gives correct results.
- base=13, N=13 → error=1. With MONT_PRECOMP_CHECK_EN undefined, the same stimulus gives error=0 and finish at 9 cycles.
- start pulsed again at cycles 3 and 5 of a run with base=5, N=13 → ignored: a single finish, and results unchanged.
- rst pulled low at cycle 4 of a run → all outputs 0 immediately and no finish. After release, a fresh request completes normally.
